coo_encoder: RTL and testbench
==============================

// Module: coo_encoder
// PURPOSE
//  Dense-to-sparse front end for the sparse matrix multiplier. Takes one square matrix as a
//  row-major stream of 4-bit elements and emits its nonzero entries as (row, col, val) triples.
//  Triples leave in row-major order through a valid/ready FIFO.
//  These triples are the COO operand stream the multiplier's A/B input ports take.
// PARAMETERS
//  DEPTH    8   triple FIFO entries (power of 2, >=2)
//  MAX_NNZ  32  max triples emitted per matrix; extra nonzeros are dropped
// PORTS
//  clk            in   1  clock, all state on rising edge
//  rst            in   1  asynchronous reset, active-high
//  in_valid_size  in   1  frame start; samples in_size (IDLE only)
//  in_size        in   1  0: 16x16 matrix, 1: 32x32 matrix
//  in_valid       in   1  dense element valid
//  in_val         in   4  dense element value
//  in_ready       out  1  encoder accepts element this cycle
//  out_valid      out  1  triple valid (FIFO non-empty)
//  out_ready      in   1  downstream accepts triple
//  out_row        out  5  triple row index
//  out_col        out  5  triple column index
//  out_val        out  4  triple value (never 0 when out_valid=1)
//  nnz            out  6  triples pushed this frame (saturates at MAX_NNZ)
//  overflow       out  1  sticky: a nonzero was dropped this frame
//  done           out  1  one-cycle pulse: frame scanned and every triple taken
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, counters 0; all outputs 0 (in_ready=0, out_valid=0, done=0).
//  FSM: IDLE -> LOAD on in_valid_size. Latch N (16/32); clear row, col, nnz, overflow.
//       LOAD -> DRAIN when the element at (N-1,N-1) is accepted.
//       DRAIN -> DONE when FIFO empty. DONE (done=1, one cycle) -> IDLE.
//  in_ready = (state==LOAD) && FIFO not full. Accept = in_valid && in_ready.
//  On every accept, col++; col wraps N-1 -> 0 with row++. Zero elements advance the counters only.
//  Accepted nonzero with nnz<MAX_NNZ: push {row,col,in_val}; nnz++.
//  Accepted nonzero with nnz==MAX_NNZ: not pushed; overflow<=1; scan continues.
//  Pop = out_valid && out_ready. out_row/col/val = FIFO head; all 0 when out_valid=0.
//  Latency: nonzero accepted in cycle t is on out_valid in cycle t+1 if FIFO was empty.
//  Push and pop in the same cycle are both honoured; count is unchanged.
//  Full FIFO: in_ready=0; no element is lost or reordered.
//  in_valid with in_ready=0 is ignored. Source must hold the element until in_ready.
//  in_valid_size outside IDLE is ignored.
//  Timing of done: last element accepted at t with FIFO empty after t -> done=1 at cycle t+2.
//  If the FIFO still holds triples, done asserts 2 cycles after the pop that empties it.
//  nnz and overflow hold their values until the next in_valid_size.
//  Reset asserted mid-frame: the frame is discarded immediately (async), block returns to the
//  reset state, and a new frame may start the cycle after rst deasserts.
// TESTING
//  16x16, only (3,5)=7, out_ready=1 -> one triple (3,5,7); nnz=1; done 2 cycles after last element.
//  16x16 all zeros -> out_valid never 1; nnz=0; overflow=0; done exactly once, 2 cycles after element 255.
//  32x32, 10 consecutive nonzeros in row 0, out_ready=0 -> in_ready drops after 8th accept.
//    After out_ready=1: 10 triples (0,0..9) in order, none lost.
//  32x32 with 33 nonzeros -> first 32 triples emitted; overflow=1; nnz=32; done still pulses.
//  rst pulse after 100 elements of a frame -> outputs 0 immediately.
//    A following 16x16 frame with (15,15)=15 yields only (15,15,15).
//  in_valid_size with in_size=1 during a 16x16 LOAD -> ignored; frame completes after 256 elements.

Source files
------------

// File: rtl/coo_encoder.sv
// coo_encoder: converts a row-major dense matrix stream into (row, col, val) COO triples behind a valid/ready FIFO
module coo_encoder #(
    parameter int DEPTH   = 8,
    parameter int MAX_NNZ = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_size,
    input  logic       in_size,
    input  logic       in_valid,
    input  logic [3:0] in_val,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_row,
    output logic [4:0] out_col,
    output logic [3:0] out_val,
    output logic [5:0] nnz,
    output logic       overflow,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [5:0] NNZ_MAX = 6'(MAX_NNZ);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FIN} state_t;

    state_t        state, state_nxt;
    logic [4:0]    n_last;
    logic [4:0]    row, col;
    logic [13:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [13:0]   head;
    logic          start, accept, nonzero, nnz_full, push, pop, last_elem, col_wrap;

    assign start     = (state == S_IDLE) && in_valid_size;
    assign in_ready  = (state == S_LOAD) && (count != FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign nonzero   = in_val != 4'd0;
    assign nnz_full  = nnz == NNZ_MAX;
    assign push      = accept && nonzero && !nnz_full;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign col_wrap  = col == n_last;
    assign last_elem = accept && col_wrap && (row == n_last);
    assign head      = mem[rd_ptr];
    assign out_row   = out_valid ? head[13:9] : 5'd0;
    assign out_col   = out_valid ? head[8:4] : 5'd0;
    assign out_val   = out_valid ? head[3:0] : 4'd0;
    assign done      = state == S_FIN;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state: scan until the bottom-right element, then wait for the FIFO to empty
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = in_valid_size ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = last_elem ? S_DRAIN : S_LOAD;
            S_DRAIN: state_nxt = (count == '0) ? S_FIN : S_DRAIN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // scan position, matrix size and per-frame statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_last   <= 5'd0;
            row      <= 5'd0;
            col      <= 5'd0;
            nnz      <= 6'd0;
            overflow <= 1'b0;
        end else if (start) begin
            n_last   <= in_size ? 5'd31 : 5'd15;
            row      <= 5'd0;
            col      <= 5'd0;
            nnz      <= 6'd0;
            overflow <= 1'b0;
        end else if (accept) begin
            col <= col_wrap ? 5'd0 : col + 5'd1;
            if (col_wrap) row <= row + 5'd1;
            if (push) nnz <= nnz + 6'd1;
            if (nonzero && nnz_full) overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
        end
    end

    // FIFO storage; contents are only visible through out_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {row, col, in_val};
    end
endmodule

// File: tb/tb_coo_encoder.sv
// tb_coo_encoder: randomized and directed frames checked against a matrix-level COO reference model
module tb_coo_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_size = 1'b0;
    logic       in_size = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_val = 4'd0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, overflow, done;
    logic [4:0] out_row, out_col;
    logic [3:0] out_val;
    logic [5:0] nnz;

    int errors = 0;
    int checks = 0;
    int mat [1024];
    int expq [$];
    int exp_nnz, exp_ovf, exp_cnt;

    always #5 clk = ~clk;

    coo_encoder dut (
        .clk(clk), .rst(rst), .in_valid_size(in_valid_size), .in_size(in_size),
        .in_valid(in_valid), .in_val(in_val), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .out_val(out_val),
        .nnz(nnz), .overflow(overflow), .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mat();
        for (int i = 0; i < 1024; i++) mat[i] = 0;
    endtask

    task automatic rand_mat(input int n, input int dens);
        for (int i = 0; i < n * n; i++) mat[i] = ($urandom_range(99) < dens) ? $urandom_range(15, 1) : 0;
    endtask

    // reference: row-major nonzeros, only the first 32 survive
    task automatic build_exp(input int n);
        int cnt;
        cnt = 0;
        expq.delete();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (mat[r * n + c] != 0) begin
                    if (cnt < 32) expq.push_back((r << 9) | (c << 4) | mat[r * n + c]);
                    cnt++;
                end
        exp_nnz = (cnt > 32) ? 32 : cnt;
        exp_ovf = (cnt > 32) ? 1 : 0;
        exp_cnt = expq.size();
    endtask

    task automatic run_frame(input bit sz, input int gap, input int rdy, input int hold,
                             input int exp_stall, input int ivs_at, input string name);
        int n, total, idx, cyc, t_acc, t_pop, t_done, done_cnt, npop, nvalid, budget, exp_done;
        n = sz ? 32 : 16;
        total = n * n;
        build_exp(n);
        idx = 0; cyc = 0; t_acc = -1; t_pop = -1; t_done = -1; done_cnt = 0; npop = 0; nvalid = 0;
        budget = 20000;
        @(negedge clk);
        in_valid_size = 1'b1; in_size = sz; in_valid = 1'b0; out_ready = 1'b0;
        #1 check({name, "_idle_in_ready"}, int'(in_ready), 0);
        while (cyc <= budget) begin
            @(negedge clk);
            in_valid_size = (cyc == ivs_at);
            if (cyc == ivs_at) in_size = 1'b1;
            in_valid = (idx < total) && ($urandom_range(99) >= gap);
            in_val = (idx < total) ? 4'(mat[idx]) : 4'd0;
            out_ready = (cyc >= hold) && ($urandom_range(99) < rdy);
            #1;
            if (hold > 0 && cyc == hold) begin
                check({name, "_stall_accepts"}, idx, exp_stall);
                check({name, "_stall_in_ready"}, int'(in_ready), 0);
            end
            if (done) begin
                done_cnt++;
                if (t_done < 0) t_done = cyc;
            end
            if (out_valid) nvalid++;
            if (out_valid && out_ready) begin
                npop++;
                t_pop = cyc;
                if (expq.size() == 0) check({name, "_extra_pop"}, 1, 0);
                else check({name, "_triple"}, int'({out_row, out_col, out_val}), expq.pop_front());
            end
            if (in_valid && in_ready) begin
                idx++;
                if (idx == total) t_acc = cyc;
            end
            cyc++;
            if (t_done >= 0 && cyc > t_done + 4) break;
        end
        in_valid = 1'b0; in_valid_size = 1'b0; out_ready = 1'b0;
        exp_done = ((t_acc > t_pop) ? t_acc : t_pop) + 2;
        check({name, "_timeout"}, (cyc > budget) ? 1 : 0, 0);
        check({name, "_accepted"}, idx, total);
        check({name, "_done_cycle"}, t_done, exp_done);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_pops"}, npop, exp_cnt);
        check({name, "_valid_seen"}, (nvalid > 0) ? 1 : 0, (exp_cnt > 0) ? 1 : 0);
        check({name, "_nnz"}, int'(nnz), exp_nnz);
        check({name, "_overflow"}, int'(overflow), exp_ovf);
        check({name, "_idle_out_valid"}, int'(out_valid), 0);
    endtask

    task automatic reset_mid();
        int nacc, cyc;
        clear_mat();
        mat[10] = 3; mat[50] = 9; mat[90] = 4;
        nacc = 0; cyc = 0;
        @(negedge clk);
        in_valid_size = 1'b1; in_size = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        while (nacc < 100 && cyc < 1000) begin
            @(negedge clk);
            in_valid_size = 1'b0; in_valid = 1'b1; in_val = 4'(mat[nacc]);
            #1;
            if (in_ready) nacc++;
            cyc++;
        end
        @(posedge clk);
        #2;
        check("rst_pre_out_valid", int'(out_valid), 1);
        check("rst_pre_nnz", int'(nnz), 3);
        rst = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_fields", int'({out_row, out_col, out_val}), 0);
        check("rst_nnz", int'(nnz), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_nnz", int'(nnz), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_out_fields", int'({out_row, out_col, out_val}), 0);
        @(negedge clk);
        rst = 1'b0;

        clear_mat(); mat[3 * 16 + 5] = 7;
        run_frame(1'b0, 0, 100, 0, 0, -1, "single");

        clear_mat();
        run_frame(1'b0, 20, 100, 0, 0, -1, "zeros");

        clear_mat(); for (int i = 0; i < 10; i++) mat[i] = i + 1;
        run_frame(1'b1, 0, 60, 20, 8, -1, "stall");

        clear_mat(); for (int k = 0; k < 33; k++) mat[k * 31] = $urandom_range(15, 1);
        run_frame(1'b1, 10, 70, 0, 0, -1, "overflow");

        reset_mid();
        clear_mat(); mat[255] = 15;
        run_frame(1'b0, 0, 100, 0, 0, -1, "post_rst");

        clear_mat(); rand_mat(16, 8);
        run_frame(1'b0, 10, 80, 0, 0, 50, "size_ignored");

        for (int f = 0; f < 4; f++) begin
            bit sz;
            sz = 1'($urandom_range(1));
            clear_mat();
            rand_mat(sz ? 32 : 16, $urandom_range(30, 2));
            run_frame(sz, $urandom_range(40), $urandom_range(100, 30), 0, 0, -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
